// File: rtl/bus_pkg.sv
// Shared definitions for the bit-serial system bus initiator.
// Contents: master FSM state enum, address/data widths, counter width and the
// address field layout (slave select in [13:12], memory address in [11:0]).
package bus_pkg;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;  // log2(ADDR_W)+1

  // Last bit index of each serial phase, sized to the bit counter.
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  // Serial address layout; bit 0 goes out first.
  typedef struct packed {
    logic [1:0]  sel;  // slave select
    logic [11:0] mem;  // memory address inside the slave
  } addr_t;

  typedef enum logic [3:0] {
    StIdle,
    StReq,
    StAddr,
    StAcka,
    StWdata,
    StWack,
    StRdata,
    StSplit,
    StDone
  } state_e;

endpackage

// File: rtl/serial_master_port_cnt.sv
// Generic up-counter with synchronous clear, used as the serial bit counter.
// Ports:
//   CLK, RSTN  clock, asynchronous active-low reset
//   i_clr      synchronous clear (wins over i_en)
//   i_en       count enable
//   o_cnt      current count
//   o_cnt_nxt  count after this clock edge, for callers that register
//              outputs from next-state values
module serial_master_port_cnt #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_cnt,
  output logic [WIDTH-1:0] o_cnt_nxt
);

  logic [WIDTH-1:0] r_cnt;

  assign o_cnt_nxt = i_clr ? '0 : (i_en ? r_cnt + 1'b1 : r_cnt);
  assign o_cnt     = r_cnt;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= o_cnt_nxt;
    end
  end

endmodule

// File: rtl/serial_master_port.sv
// Initiator end of the bit-serial system bus.
// Takes one parallel request from the local user, wins the bus from the
// arbiter, serialises a 14-bit address (LSB first), then sends 8 write bits
// or collects 8 read bits, handling slave ACK and arbiter split/resume.
// Optional build macro MASTER_ACK_TIMEOUT_EN: abort after ACK_TO cycles
// without B_ACK in the address/write acknowledge waits and pulse D_ERR.
// Ports:
//   CLK, RSTN              clock, asynchronous active-low reset
//   D_START/D_RW/D_ADDR/D_WDATA  user request (sampled in idle only)
//   D_RDATA/D_DVALID/D_BUSY/D_ERR  user response
//   B_REQ/B_GRANT          arbiter handshake
//   B_VALID/B_RW/B_BUS_OUT frame strobe, direction, serial out
//   B_BUS_IN/B_ACK/B_READY slave serial in, acknowledge, ready
//   B_SPLIT/B_SPL_RESUME   arbiter split and resume
// All outputs are registered and decoded from the next state.
module serial_master_port
  import bus_pkg::*;
`ifdef MASTER_ACK_TIMEOUT_EN
#(
  parameter int unsigned ACK_TO = 15
)
`endif
(
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              D_START,
  input  logic              D_RW,
  input  logic [ADDR_W-1:0] D_ADDR,
  input  logic [DATA_W-1:0] D_WDATA,
  output logic [DATA_W-1:0] D_RDATA,
  output logic              D_DVALID,
  output logic              D_BUSY,
  output logic              D_ERR,
  output logic              B_REQ,
  input  logic              B_GRANT,
  output logic              B_VALID,
  output logic              B_RW,
  output logic              B_BUS_OUT,
  input  logic              B_BUS_IN,
  input  logic              B_ACK,
  input  logic              B_READY,
  input  logic              B_SPLIT,
  input  logic              B_SPL_RESUME
);

  state_e            r_state, w_state_nxt;
  addr_t             r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rw;
  logic [DATA_W-1:0] r_rbuf, w_rbuf_nxt;
  logic [CNT_W-1:0]  w_cnt, w_cnt_nxt;
  logic              w_cnt_clr, w_cnt_en;
  logic              w_accept, w_abort, w_split_req, w_timeout;
  logic              w_bus_out_nxt;

  logic [DATA_W-1:0] r_rdata;
  logic              r_dvalid, r_busy, r_err, r_b_req, r_b_valid, r_b_rw, r_bus_out;

  serial_master_port_cnt #(
    .WIDTH (CNT_W)
  ) u_bitcnt (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .i_clr     (w_cnt_clr),
    .i_en      (w_cnt_en),
    .o_cnt     (w_cnt),
    .o_cnt_nxt (w_cnt_nxt)
  );

`ifdef MASTER_ACK_TIMEOUT_EN
  localparam int unsigned WaitW = $clog2(ACK_TO + 1);
  logic [WaitW-1:0] r_wait;

  // Fires on the ACK_TO-th consecutive wait cycle without B_ACK.
  assign w_timeout = (r_wait == WaitW'(ACK_TO - 1));

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_wait <= '0;
    end else if ((r_state == StAcka || r_state == StWack) && (w_state_nxt == r_state)) begin
      r_wait <= r_wait + 1'b1;
    end else begin
      r_wait <= '0;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Split only counts when resume is not raised in the same cycle.
  assign w_split_req = B_SPLIT & ~B_SPL_RESUME;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_cnt_en    = 1'b0;
    w_rbuf_nxt  = r_rbuf;
    w_accept    = 1'b0;
    w_abort     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (D_START) begin
          w_accept    = 1'b1;
          w_state_nxt = StReq;
        end
      end
      StReq: begin
        if (B_GRANT) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = StAddr;
        end
      end
      StAddr: begin
        if (w_cnt == ADDR_LAST) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = StAcka;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      StAcka: begin
        if (B_ACK) begin
          w_cnt_clr = 1'b1;
          if (r_rw)             w_state_nxt = StWdata;
          else if (w_split_req) w_state_nxt = StSplit;
          else                  w_state_nxt = StRdata;
        end else if (w_timeout) begin
          w_abort = 1'b1;
        end
      end
      StWdata: begin
        if (w_cnt == DATA_LAST) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = StWack;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      StWack: begin
        if (B_ACK)          w_state_nxt = StDone;
        else if (w_timeout) w_abort     = 1'b1;
      end
      StRdata: begin
        if (w_split_req) begin
          // Bit counter is held so the read resumes at the same bit.
          w_state_nxt = StSplit;
        end else if (B_READY) begin
          w_rbuf_nxt[w_cnt[2:0]] = B_BUS_IN;
          if (w_cnt == DATA_LAST) begin
            w_cnt_clr   = 1'b1;
            w_state_nxt = StDone;
          end else begin
            w_cnt_en = 1'b1;
          end
        end
      end
      StSplit: begin
        if (B_SPL_RESUME || !B_SPLIT) w_state_nxt = StRdata;
      end
      StDone: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
    if (w_abort) begin
      w_state_nxt = StIdle;
      w_cnt_clr   = 1'b1;
    end
  end

  always_comb begin
    w_bus_out_nxt = 1'b0;
    if (w_state_nxt == StAddr)       w_bus_out_nxt = r_addr[w_cnt_nxt];
    else if (w_state_nxt == StWdata) w_bus_out_nxt = r_wdata[w_cnt_nxt[2:0]];
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state   <= StIdle;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rw      <= 1'b0;
      r_rbuf    <= '0;
      r_rdata   <= '0;
      r_dvalid  <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_b_req   <= 1'b0;
      r_b_valid <= 1'b0;
      r_b_rw    <= 1'b0;
      r_bus_out <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rbuf  <= w_rbuf_nxt;
      if (w_accept) begin
        r_addr  <= D_ADDR;
        r_wdata <= D_WDATA;
        r_rw    <= D_RW;
      end
      r_busy    <= (w_state_nxt != StIdle);
      r_b_req   <= (w_state_nxt != StIdle);
      r_b_valid <= (w_state_nxt != StIdle) && (w_state_nxt != StReq) &&
                   (w_state_nxt != StSplit);
      r_b_rw    <= (w_state_nxt == StIdle) ? 1'b0 : (w_accept ? D_RW : r_rw);
      r_bus_out <= w_bus_out_nxt;
      r_dvalid  <= (w_state_nxt == StDone);
      r_err     <= w_abort;
      if (w_state_nxt == StDone && !r_rw) r_rdata <= w_rbuf_nxt;
    end
  end

  assign D_RDATA   = r_rdata;
  assign D_DVALID  = r_dvalid;
  assign D_BUSY    = r_busy;
  assign D_ERR     = r_err;
  assign B_REQ     = r_b_req;
  assign B_VALID   = r_b_valid;
  assign B_RW      = r_b_rw;
  assign B_BUS_OUT = r_bus_out;

endmodule

// File: tb/tb_serial_master_port.sv
// Bench for serial_master_port: a table of transactions (write/read, grant
// delay, ACK delay, ready gaps, split/resume) plus hand-written sequences for
// mid-frame reset and, in the MASTER_ACK_TIMEOUT_EN build, ACK timeout.
module tb_serial_master_port;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        D_START = 1'b0;
  logic        D_RW = 1'b0;
  logic [13:0] D_ADDR = '0;
  logic [7:0]  D_WDATA = '0;
  logic [7:0]  D_RDATA;
  logic        D_DVALID, D_BUSY, D_ERR;
  logic        B_REQ;
  logic        B_GRANT = 1'b0;
  logic        B_VALID, B_RW, B_BUS_OUT;
  logic        B_BUS_IN = 1'b0;
  logic        B_ACK = 1'b0;
  logic        B_READY = 1'b0;
  logic        B_SPLIT = 1'b0;
  logic        B_SPL_RESUME = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [7:0] last_rd = 8'h00;

  always #5 CLK = ~CLK;

  serial_master_port dut (
    .CLK          (CLK),
    .RSTN         (RSTN),
    .D_START      (D_START),
    .D_RW         (D_RW),
    .D_ADDR       (D_ADDR),
    .D_WDATA      (D_WDATA),
    .D_RDATA      (D_RDATA),
    .D_DVALID     (D_DVALID),
    .D_BUSY       (D_BUSY),
    .D_ERR        (D_ERR),
    .B_REQ        (B_REQ),
    .B_GRANT      (B_GRANT),
    .B_VALID      (B_VALID),
    .B_RW         (B_RW),
    .B_BUS_OUT    (B_BUS_OUT),
    .B_BUS_IN     (B_BUS_IN),
    .B_ACK        (B_ACK),
    .B_READY      (B_READY),
    .B_SPLIT      (B_SPLIT),
    .B_SPL_RESUME (B_SPL_RESUME)
  );

  // The arbiter model never revokes grant while a frame is active.
  always @(posedge CLK) begin
    if (RSTN && B_VALID && !B_GRANT) begin
      failures++;
      $display("FAIL grant_held: B_VALID=1 with B_GRANT=0 at %0t", $time);
    end
  end

  typedef struct {
    logic        rw;
    logic [13:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rd;        // slave read data
    int          gdly;      // grant delay cycles
    int          ackdly;    // cycles before ACK
    int          gap;       // read bit preceded by a not-ready cycle (-1 none)
    int          split_at;  // read bit at which split hits (-1 none)
    int          split_len;
    int          sr_at;     // read bit with split and resume together (-1 none)
    logic        noise;     // pulse D_START while waiting for grant
    logic [13:0] exp_addr;  // serial address bits, bit i = i-th bit on the wire
    logic [7:0]  exp_data;  // serial write bits or D_RDATA at completion
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int n, input vec_t v);
    logic [13:0] cap_a;
    logic [7:0]  cap_d;
    int          bad_frame;
    int          bad_wait;
    int          bad_split;
    bad_frame = 0;
    bad_wait  = 0;
    bad_split = 0;
    cap_a     = '0;
    cap_d     = '0;
    D_RW    = v.rw;
    D_ADDR  = v.addr;
    D_WDATA = v.wdata;
    D_START = 1'b1;
    @(negedge CLK);
    D_START = 1'b0;
    // Scramble the request inputs; the shadow registers must hold.
    D_RW    = ~v.rw;
    D_ADDR  = ~v.addr;
    D_WDATA = ~v.wdata;
    chk($sformatf("v%0d_busy_on_accept", n), D_BUSY, 1);
    chk($sformatf("v%0d_req_on_accept", n), B_REQ, 1);
    chk($sformatf("v%0d_valid_before_grant", n), B_VALID, 0);
    for (int i = 0; i < v.gdly; i++) begin
      if (v.noise) D_START = i[0];
      @(negedge CLK);
      if (B_REQ !== 1'b1 || B_VALID !== 1'b0 || D_BUSY !== 1'b1) bad_wait++;
    end
    D_START = 1'b0;
    B_GRANT = 1'b1;
    @(negedge CLK);
    for (int i = 0; i < 14; i++) begin
      cap_a[i] = B_BUS_OUT;
      if (B_VALID !== 1'b1 || B_RW !== v.rw) bad_frame++;
      @(negedge CLK);
    end
    chk($sformatf("v%0d_grant_wait", n), bad_wait, 0);
    chk($sformatf("v%0d_addr_bits", n), cap_a, v.exp_addr);
    chk($sformatf("v%0d_acka_bus", n), {B_VALID, B_BUS_OUT}, 2'b10);
    for (int j = 0; j < v.ackdly; j++) begin
      @(negedge CLK);
      if (B_VALID !== 1'b1 || B_BUS_OUT !== 1'b0) bad_frame++;
    end
    B_ACK = 1'b1;
    @(negedge CLK);
    B_ACK = 1'b0;
    if (v.rw) begin
      for (int i = 0; i < 8; i++) begin
        cap_d[i] = B_BUS_OUT;
        if (B_VALID !== 1'b1 || B_RW !== 1'b1) bad_frame++;
        @(negedge CLK);
      end
      chk($sformatf("v%0d_wdata_bits", n), cap_d, v.exp_data);
      chk($sformatf("v%0d_wack_bus", n), {B_VALID, B_BUS_OUT, D_DVALID}, 3'b100);
      for (int j = 0; j < v.ackdly; j++) begin
        @(negedge CLK);
        if (B_VALID !== 1'b1 || D_DVALID !== 1'b0) bad_frame++;
      end
      B_ACK = 1'b1;
      @(negedge CLK);
      B_ACK = 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (i == v.gap) begin
          B_READY  = 1'b0;
          B_BUS_IN = ~v.rd[i];
          @(negedge CLK);
          if (D_DVALID !== 1'b0) bad_frame++;
        end
        if (i == v.split_at) begin
          B_SPLIT  = 1'b1;
          B_READY  = 1'b1;
          B_BUS_IN = ~v.rd[i];
          @(negedge CLK);
          B_READY = 1'b0;
          chk($sformatf("v%0d_split_entered", n), {B_VALID, B_REQ}, 2'b01);
          for (int j = 0; j < v.split_len; j++) begin
            if (B_VALID !== 1'b0 || B_REQ !== 1'b1 || D_BUSY !== 1'b1) bad_split++;
            @(negedge CLK);
          end
          B_SPL_RESUME = 1'b1;
          @(negedge CLK);
          B_SPL_RESUME = 1'b0;
          B_SPLIT      = 1'b0;
          chk($sformatf("v%0d_split_hold", n), bad_split, 0);
          chk($sformatf("v%0d_resume_valid", n), B_VALID, 1);
        end
        B_SPLIT      = (i == v.sr_at);
        B_SPL_RESUME = (i == v.sr_at);
        B_READY      = 1'b1;
        B_BUS_IN     = v.rd[i];
        @(negedge CLK);
        B_SPLIT      = 1'b0;
        B_SPL_RESUME = 1'b0;
        if (B_VALID !== 1'b1 || B_RW !== 1'b0) bad_frame++;
        if (i < 7 && D_DVALID !== 1'b0) bad_frame++;
      end
      B_READY = 1'b0;
    end
    chk($sformatf("v%0d_frame", n), bad_frame, 0);
    chk($sformatf("v%0d_done_dvalid", n), D_DVALID, 1);
    chk($sformatf("v%0d_done_busy", n), D_BUSY, 1);
    if (!v.rw) last_rd = v.exp_data;
    chk($sformatf("v%0d_rdata", n), D_RDATA, last_rd);
    @(negedge CLK);
    B_GRANT = 1'b0;
    chk($sformatf("v%0d_after_done", n), {D_DVALID, D_BUSY, B_REQ, B_VALID, D_ERR}, 5'b0);
    D_RW    = 1'b0;
    D_ADDR  = '0;
    D_WDATA = '0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 14'h0123, 8'h5A, 8'h00, 0, 0, -1, -1, 0, -1, 1'b0, 14'h0123, 8'h5A};
    vecs[1] = '{1'b0, 14'h2ABC, 8'h00, 8'hAD, 0, 1, 3, -1, 0, -1, 1'b0, 14'h2ABC, 8'hAD};
    vecs[2] = '{1'b0, 14'h1005, 8'h00, 8'h3C, 2, 0, -1, 3, 20, -1, 1'b0, 14'h1005, 8'h3C};
    vecs[3] = '{1'b1, 14'h3FFF, 8'h81, 8'h00, 10, 2, -1, -1, 0, -1, 1'b1, 14'h3FFF, 8'h81};
    vecs[4] = '{1'b0, 14'h0000, 8'h00, 8'hFF, 0, 3, 0, -1, 0, 5, 1'b0, 14'h0000, 8'hFF};
    vecs[5] = '{1'b1, 14'h2000, 8'h00, 8'h00, 1, 0, -1, -1, 0, -1, 1'b0, 14'h2000, 8'h00};

    repeat (2) @(negedge CLK);
    chk("reset_outputs", {D_RDATA, D_DVALID, D_BUSY, D_ERR, B_REQ, B_VALID, B_RW, B_BUS_OUT}, '0);
    RSTN = 1'b1;
    @(negedge CLK);
    chk("idle_outputs", {D_BUSY, B_REQ, B_VALID}, 3'b000);

    for (int n = 0; n < 6; n++) run_vec(n, vecs[n]);

    // Reset while address bit 7 is on the wire.
    D_RW    = 1'b1;
    D_ADDR  = 14'h00FF;
    D_WDATA = 8'hC3;
    D_START = 1'b1;
    @(negedge CLK);
    D_START = 1'b0;
    B_GRANT = 1'b1;
    @(negedge CLK);
    repeat (7) @(negedge CLK);
    chk("rst_pre_bit7", {B_VALID, B_BUS_OUT}, 2'b11);
    RSTN = 1'b0;
    #1;
    chk("rst_mid_frame_outputs",
        {D_RDATA, D_DVALID, D_BUSY, D_ERR, B_REQ, B_VALID, B_RW, B_BUS_OUT}, '0);
    last_rd = 8'h00;
    B_GRANT = 1'b0;
    @(negedge CLK);
    RSTN = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_no_resume", {D_BUSY, B_REQ, B_VALID}, 3'b000);
    run_vec(10, vecs[0]);

`ifdef MASTER_ACK_TIMEOUT_EN
    begin
      int err_at;
      int dv;
      err_at  = -1;
      dv      = 0;
      D_RW    = 1'b1;
      D_ADDR  = 14'h0042;
      D_WDATA = 8'h11;
      D_START = 1'b1;
      @(negedge CLK);
      D_START = 1'b0;
      B_GRANT = 1'b1;
      @(negedge CLK);
      repeat (14) @(negedge CLK);
      chk("to_in_acka", {B_VALID, B_BUS_OUT}, 2'b10);
      for (int j = 1; j <= 20; j++) begin
        @(negedge CLK);
        if (D_ERR === 1'b1 && err_at < 0) err_at = j;
        if (D_DVALID === 1'b1) dv++;
        if (j == 16) B_GRANT = 1'b0;
      end
      chk("to_err_cycle", err_at, 15);
      chk("to_no_dvalid", dv, 0);
      chk("to_idle", {D_BUSY, B_REQ, B_VALID, D_ERR}, 4'b0000);
      chk("to_rdata_kept", D_RDATA, last_rd);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
